// File: rtl/udp_tx_framer.sv
// UDP transmit framer: buffers one payload while accumulating the RFC 768 checksum
// (IPv4 pseudo-header included), then streams the 8-byte header and payload to the IP stage.
module udp_tx_framer #(
  parameter int MAX_PAYLOAD = 64,
  parameter int ADDR_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic        pl_valid,
  input  logic [7:0]  pl_data,
  input  logic        pl_last,
  output logic        pl_ready,
  output logic        ip_start,
  output logic [7:0]  ip_data,
  output logic [15:0] ip_len,
  input  logic        ip_busy
);

  typedef enum logic [3:0] {IDLE, LOAD, FOLD1, FOLD2, WAIT_IP, START, HDR, PAY, END} state_t;

  localparam logic [15:0]       MAX_CNT  = 16'(MAX_PAYLOAD);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state, state_n;
  logic [15:0]       count, count_inc, udp_len, out_idx;
  logic [31:0]       sum, hdr_sum, pad_word;
  logic [16:0]       fold1;
  logic [15:0]       fold2, csum, csum_raw;
  logic [7:0]        hi_byte, hdr_byte, rd_data;
  logic [31:0]       src_ip_q, dst_ip_q;
  logic [15:0]       src_port_q, dst_port_q;
  logic [ADDR_W-1:0] wr_addr, rd_ptr;
  logic              accept;
  logic [7:0]        mem [0:(2**ADDR_W)-1];

  assign pl_ready  = rst && (state == IDLE || state == LOAD);
  assign accept    = pl_valid && pl_ready;
  assign count_inc = count + 16'd1;
  assign udp_len   = count + 16'd8;
  assign wr_addr   = (state == IDLE) ? '0 : count[ADDR_W-1:0];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = (pl_last || MAX_CNT == 16'd1) ? FOLD1 : LOAD;
      LOAD:    if (accept && (pl_last || count_inc == MAX_CNT)) state_n = FOLD1;
      FOLD1:   state_n = FOLD2;
      FOLD2:   state_n = WAIT_IP;
      WAIT_IP: if (!ip_busy) state_n = START;
      START:   state_n = HDR;
      HDR:     if (out_idx == 16'd7) state_n = PAY;
      PAY:     if (out_idx == udp_len - 16'd1) state_n = END;
      END:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pseudo-header plus UDP header words; the checksum field itself contributes zero.
  always_comb begin
    hdr_sum  = {16'h0, src_ip_q[31:16]} + {16'h0, src_ip_q[15:0]}
             + {16'h0, dst_ip_q[31:16]} + {16'h0, dst_ip_q[15:0]}
             + 32'h0000_0011 + {15'h0, udp_len, 1'b0}
             + {16'h0, src_port_q} + {16'h0, dst_port_q};
    pad_word = count[0] ? {16'h0, hi_byte, 8'h00} : 32'h0;
    fold1    = {1'b0, sum[31:16]} + {1'b0, sum[15:0]};
    fold2    = fold1[15:0] + {15'h0, fold1[16]};
    csum_raw = ~fold2;
  end

  always_comb begin
    hdr_byte = 8'h00;
    case (out_idx[2:0])
      3'd0: hdr_byte = src_port_q[15:8];
      3'd1: hdr_byte = src_port_q[7:0];
      3'd2: hdr_byte = dst_port_q[15:8];
      3'd3: hdr_byte = dst_port_q[7:0];
      3'd4: hdr_byte = udp_len[15:8];
      3'd5: hdr_byte = udp_len[7:0];
      3'd6: hdr_byte = csum[15:8];
      3'd7: hdr_byte = csum[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // The read port runs one cycle ahead so rd_data is ready when PAY consumes it.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= pl_data;
    rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count      <= 16'h0;
      sum        <= 32'h0;
      hi_byte    <= 8'h00;
      csum       <= 16'h0;
      out_idx    <= 16'h0;
      rd_ptr     <= '0;
      src_ip_q   <= 32'h0;
      dst_ip_q   <= 32'h0;
      src_port_q <= 16'h0;
      dst_port_q <= 16'h0;
      ip_start   <= 1'b0;
      ip_data    <= 8'h00;
      ip_len     <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          sum   <= 32'h0;
          count <= 16'h0;
          if (accept) begin
            src_ip_q   <= src_ip;
            dst_ip_q   <= dst_ip;
            src_port_q <= src_port;
            dst_port_q <= dst_port;
            hi_byte    <= pl_data;
            count      <= 16'd1;
          end
        end
        LOAD: begin
          if (accept) begin
            count <= count_inc;
            if (count[0]) sum <= sum + {16'h0, hi_byte, pl_data};
            else          hi_byte <= pl_data;
          end
        end
        FOLD1: sum <= sum + pad_word + hdr_sum;
        FOLD2: csum <= (csum_raw == 16'h0) ? 16'hFFFF : csum_raw;
        WAIT_IP: begin
          out_idx <= 16'h0;
          if (!ip_busy) begin
            ip_start <= 1'b1;
            ip_len   <= udp_len;
          end
        end
        START: begin
          ip_data <= hdr_byte;
          out_idx <= out_idx + 16'd1;
          rd_ptr  <= '0;
        end
        HDR: begin
          ip_data <= hdr_byte;
          out_idx <= out_idx + 16'd1;
          if (out_idx == 16'd7) rd_ptr <= rd_ptr + ADDR_ONE;
        end
        PAY: begin
          ip_data <= rd_data;
          out_idx <= out_idx + 16'd1;
          rd_ptr  <= rd_ptr + ADDR_ONE;
        end
        END: ip_start <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
